// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port (1-cycle read latency, word addressed)
//   between instruction fetch and the MEM-stage load/store unit.
//   The data side has priority. Fetch is force-granted after STARVE_MAX
//   consecutive denied cycles. Read data is routed back only to the
//   requester that issued the read.
//
// Optional build macro: MEM_ARB_PERF_CNT_EN adds the perf_conflict and
// perf_force cycle counters. When the macro is undefined, the counters and
// their ports are absent. Grant behaviour is the same in both builds.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   if_req/if_addr      fetch read request and word address
//   if_gnt/if_stall     fetch issued this cycle / fetch held off
//   if_rvalid/if_rdata  fetch read return (rdata is 0 when not valid)
//   d_req/d_we/d_be     data request; store flag; store byte enables
//   d_addr/d_wdata      data word address; store data
//   d_gnt/d_stall       data issued this cycle (also the store ack) / held off
//   d_rvalid/d_rdata    load return (rdata is 0 when not valid)
//   mem_en/mem_we       memory enable; per-byte write enable
//   mem_addr/mem_din    memory word address; write data
//   mem_dout            memory read data, one cycle after the read is issued
//   perf_conflict       (macro only) cycles with both requests asserted
//   perf_force          (macro only) cycles with a forced fetch grant
//
// Read-owner states
//   state    | meaning
//   OWN_NONE | no read is outstanding, so mem_dout is not returned
//   OWN_IF   | mem_dout belongs to fetch this cycle
//   OWN_D    | mem_dout belongs to the load unit this cycle

module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:2] if_addr,
    output logic        if_gnt,
    output logic        if_stall,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_stall,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_force
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t     rd_owner;
    owner_t     rd_owner_nxt;
    logic [7:0] starve_cnt;
    logic       force_if;

    // Grant logic. A starved fetch takes the port for one cycle. Otherwise
    // the data side wins. This construction makes the two grants exclusive.
    assign force_if = if_req && (starve_cnt == STARVE_LIM);
    assign d_gnt    = d_req & ~force_if;
    assign if_gnt   = if_req & ~d_gnt;
    assign if_stall = if_req & ~if_gnt;
    assign d_stall  = d_req & ~d_gnt;

    assign mem_en   = if_gnt | d_gnt;
    assign mem_addr = d_gnt ? d_addr : if_addr;
    assign mem_we   = (d_gnt & d_we) ? d_be : 4'b0000;
    assign mem_din  = d_wdata;

    // Counts consecutive denied fetch cycles. The counter clears on any cycle
    // in which fetch is granted or not requesting. The saturating branch
    // only guards against a wrap if the compare above is ever changed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (if_req & ~if_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end else begin
            starve_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // The next owner is registered on the same edge that the current return
    // is consumed. This allows back-to-back reads with no bubble. Stores,
    // including stores with d_be=0, never claim ownership.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        if_rdata     = 32'd0;
        d_rdata      = 32'd0;

        if (if_gnt) begin
            rd_owner_nxt = OWN_IF;
        end else if (d_gnt & ~d_we) begin
            rd_owner_nxt = OWN_D;
        end

        case (rd_owner)
            OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_dout;
            end
            OWN_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_dout;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict <= 32'd0;
            perf_force    <= 32'd0;
        end else begin
            if (if_req & d_req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (force_if) begin
                perf_force <= perf_force + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. u_dut uses STARVE_MAX=4. u_dut1
//   uses STARVE_MAX=1, shares the inputs and is checked in the
//   starvation phase only. A small byte-writable synchronous memory model
//   drives mem_dout from u_dut's port. Each word is initialised to
//   0xC0DE0000 | index.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:2] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:2] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_dout;

    logic        if_gnt, if_stall, if_rvalid, d_gnt, d_stall, d_rvalid, mem_en;
    logic [31:0] if_rdata, d_rdata, mem_din;
    logic [3:0]  mem_we;
    logic [31:2] mem_addr;

    logic        if_gnt_1, if_stall_1, if_rvalid_1, d_gnt_1, d_stall_1, d_rvalid_1, mem_en_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_din_1;
    logic [3:0]  mem_we_1;
    logic [31:2] mem_addr_1;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_conflict, perf_force, perf_conflict_1, perf_force_1;
`endif

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_conflict(perf_conflict), .perf_force(perf_force)
`endif
    );

    mem_port_arbiter #(.STARVE_MAX(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_stall(if_stall_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_1), .d_stall(d_stall_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_din(mem_din_1),
        .mem_dout(mem_dout)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_conflict(perf_conflict_1), .perf_force(perf_force_1)
`endif
    );

    // Memory model. It loads its contents once on the first clock edge.
    logic [31:0] mem_arr [0:255];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem_arr[i] <= 32'hC0DE_0000 | 32'(i);
            end
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) begin
                    mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
            mem_dout <= mem_arr[mem_addr[9:2]];
        end
    end

    function automatic logic [31:0] exp_word(input int a);
        return 32'hC0DE_0000 | 32'(a & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ir, input logic [29:0] ia, input logic dr,
                       input logic we, input logic [3:0] be, input logic [29:0] da,
                       input logic [31:0] wd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = we;
        d_be    = be;
        d_addr  = da;
        d_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #3;
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 0);
        drv(1, 30'h10, 0, 0, 0, 0, 0);
        #1;
        chk("rst_comb_if_gnt", 32'(if_gnt), 1);
        chk("rst_comb_mem_en", 32'(mem_en), 1);
        tick();
        chk("rst_hold_if_rvalid", 32'(if_rvalid), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // Fetch only, three cycles at address 0x10
        for (int c = 1; c <= 3; c++) begin
            drv(1, 30'h10, 0, 0, 0, 0, 0);
            #1;
            chk("fetch_if_gnt", 32'(if_gnt), 1);
            chk("fetch_if_stall", 32'(if_stall), 0);
            chk("fetch_mem_addr", 32'(mem_addr), 32'h10);
            chk("fetch_mem_we", 32'(mem_we), 0);
            tick();
            chk("fetch_if_rvalid", 32'(if_rvalid), 1);
            chk("fetch_if_rdata", if_rdata, exp_word(16));
            chk("fetch_d_rvalid", 32'(d_rvalid), 0);
            chk("fetch_d_rdata", d_rdata, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("idle_mem_en", 32'(mem_en), 0);
        tick();
        chk("idle_if_rvalid", 32'(if_rvalid), 0);
        chk("idle_if_rdata", if_rdata, 0);

        // Starvation with both requests held. u_dut (max 4) forces fetch on
        // cycles 5 and 10. u_dut1 (max 1) alternates D, IF.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drv(1, 30'h11, 1, 0, 4'hF, 30'h30, 32'h1234_5678);
        for (int c = 1; c <= 10; c++) begin
            logic e_if0, e_if1;
            int   a0;
            e_if0 = (c % 5 == 0);
            e_if1 = (c % 2 == 0);
            a0    = e_if0 ? 'h11 : 'h30;
            #1;
            chk("starve_if_gnt", 32'(if_gnt), 32'(e_if0));
            chk("starve_d_gnt", 32'(d_gnt), 32'(!e_if0));
            chk("starve_if_stall", 32'(if_stall), 32'(!e_if0));
            chk("starve_d_stall", 32'(d_stall), 32'(e_if0));
            chk("starve_mem_addr", 32'(mem_addr), 32'(a0));
            chk("starve_mem_we", 32'(mem_we), 0);
            chk("sm1_if_gnt", 32'(if_gnt_1), 32'(e_if1));
            chk("sm1_d_gnt", 32'(d_gnt_1), 32'(!e_if1));
            chk("sm1_stalls", {30'd0, if_stall_1, d_stall_1}, {30'd0, !e_if1, e_if1});
            chk("sm1_mem_en", 32'(mem_en_1), 1);
            chk("sm1_mem_we", 32'(mem_we_1), 0);
            chk("sm1_mem_addr", 32'(mem_addr_1), e_if1 ? 32'h11 : 32'h30);
            chk("sm1_mem_din", mem_din_1, 32'h1234_5678);
            chk("starve_mem_din", mem_din, 32'h1234_5678);
            tick();
            chk("starve_if_rvalid", 32'(if_rvalid), 32'(e_if0));
            chk("starve_d_rvalid", 32'(d_rvalid), 32'(!e_if0));
            chk("starve_if_rdata", if_rdata, e_if0 ? exp_word(a0) : 0);
            chk("starve_d_rdata", d_rdata, e_if0 ? 0 : exp_word(a0));
            chk("sm1_if_rvalid", 32'(if_rvalid_1), 32'(e_if1));
            chk("sm1_d_rvalid", 32'(d_rvalid_1), 32'(!e_if1));
            chk("sm1_if_rdata", if_rdata_1, e_if1 ? exp_word(a0) : 0);
            chk("sm1_d_rdata", d_rdata_1, e_if1 ? 0 : exp_word(a0));
        end
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_conflict", perf_conflict, 10);
        chk("perf_force", perf_force, 2);
        chk("perf_conflict_1", perf_conflict_1, 10);
        chk("perf_force_1", perf_force_1, 5);
`endif
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Stores: a partial store, then a store with no byte enables, then
        // loads that read both words back
        drv(0, 0, 1, 1, 4'b0011, 30'h20, 32'hDEAD_BEEF);
        #1;
        chk("st_mem_we", 32'(mem_we), 32'h3);
        chk("st_mem_din", mem_din, 32'hDEAD_BEEF);
        chk("st_d_gnt", 32'(d_gnt), 1);
        chk("st_mem_addr", 32'(mem_addr), 32'h20);
        tick();
        chk("st_no_rvalid", 32'(d_rvalid), 0);
        chk("st_no_rdata", d_rdata, 0);
        drv(0, 0, 1, 1, 4'b0000, 30'h21, 32'hFFFF_FFFF);
        #1;
        chk("st0_mem_we", 32'(mem_we), 0);
        chk("st0_mem_en", 32'(mem_en), 1);
        chk("st0_d_gnt", 32'(d_gnt), 1);
        tick();
        chk("st0_no_rvalid", 32'(d_rvalid), 0);
        drv(0, 0, 1, 0, 4'hF, 30'h20, 0);
        #1;
        chk("ld_mem_we", 32'(mem_we), 0);
        tick();
        chk("ld20_rvalid", 32'(d_rvalid), 1);
        chk("ld20_rdata", d_rdata, 32'hC0DE_BEEF);
        drv(0, 0, 1, 0, 4'hF, 30'h21, 0);
        tick();
        chk("ld21_rdata", d_rdata, exp_word('h21));
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset while a load return is pending. The starve counter is at 2.
        drv(1, 30'h12, 1, 0, 0, 30'h22, 0);
        #1;
        chk("mr_d_gnt_a", 32'(d_gnt), 1);
        tick();
        chk("mr_d_rvalid_a", 32'(d_rvalid), 1);
        tick();
        chk("mr_d_rvalid_b", 32'(d_rvalid), 1);
        chk("mr_d_rdata_b", d_rdata, exp_word('h22));
        #1;
        rst = 1'b1;
        #1;
        chk("mr_rst_d_rvalid", 32'(d_rvalid), 0);
        chk("mr_rst_d_rdata", d_rdata, 0);
        chk("mr_rst_if_rvalid", 32'(if_rvalid), 0);
        chk("mr_rst_d_gnt", 32'(d_gnt), 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("mr_hold_d_rvalid", 32'(d_rvalid), 0);
        rst = 1'b0;
        tick();
        chk("mr_post_d_rvalid", 32'(d_rvalid), 0);
        // A cleared counter gives exactly four data wins before fetch is forced
        drv(1, 30'h12, 1, 0, 0, 30'h22, 0);
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk("mr_cnt_if_gnt", 32'(if_gnt), 32'(c == 5));
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Alternation: loads on cycles 1 and 3, fetch on every cycle
        for (int c = 1; c <= 4; c++) begin
            logic dr;
            dr = (c % 2 == 1);
            drv(1, 30'(32'h50 + c), dr, 0, 0, 30'(32'h40 + c), 0);
            #1;
            chk("alt_d_gnt", 32'(d_gnt), 32'(dr));
            chk("alt_if_gnt", 32'(if_gnt), 32'(!dr));
            tick();
            chk("alt_d_rvalid", 32'(d_rvalid), 32'(dr));
            chk("alt_if_rvalid", 32'(if_rvalid), 32'(!dr));
            chk("alt_d_rdata", d_rdata, dr ? exp_word('h40 + c) : 0);
            chk("alt_if_rdata", if_rdata, dr ? 0 : exp_word('h50 + c));
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
